// File: rtl/fft_stage_ctrl.sv
// Frame sequencer for the 64-point radix-2 FFT: load, STG_NUM butterfly stages over
// ping-pong banks, bit-reversed unload. Optional block scaling under `FFT_CTRL_SCALE_EN.
`ifndef STG_WID
`define STG_WID 3
`endif

module fft_stage_ctrl #(
  parameter int unsigned FFT_LEN  = 64,
  parameter int unsigned ADDR_WID = 6,
  parameter int unsigned STG_NUM  = 6,
  parameter int unsigned BFLY_LAT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic                  din_vld_i,
  output logic                  din_rdy_o,
  output logic                  ld_we_o,
  output logic [ADDR_WID-1:0]   ld_addr_o,
  output logic [`STG_WID-1:0]   stage_o,
  output logic                  bf_en_o,
  output logic                  wb_en_o,
  output logic                  bank_sel_o,
  output logic                  dout_vld_o,
  input  logic                  dout_rdy_i,
  output logic [ADDR_WID-1:0]   ul_addr_o,
  output logic                  dout_last_o
`ifdef FFT_CTRL_SCALE_EN
  ,
  output logic                  scale_o,
  output logic [`STG_WID-1:0]   blk_exp_o
`endif
);

  localparam int unsigned STG_W = `STG_WID;
  localparam int unsigned LAT_W = $clog2(BFLY_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CALC, S_WAIT, S_UNLOAD, S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [ADDR_WID-1:0] cnt;
  logic [STG_W-1:0]   stage;
  logic [LAT_W-1:0]   lat_cnt;
  logic               bank_sel;
  logic               cnt_last, lat_zero, stg_last;
`ifdef FFT_CTRL_SCALE_EN
  logic [STG_W-1:0]   blk_exp;
`endif

  assign cnt_last = (cnt == ADDR_WID'(FFT_LEN - 1));
  assign lat_zero = (lat_cnt == '0);
  assign stg_last = (stage == STG_W'(STG_NUM - 1));

  function automatic logic [ADDR_WID-1:0] bitrev(input logic [ADDR_WID-1:0] a);
    logic [ADDR_WID-1:0] r;
    for (int i = 0; i < ADDR_WID; i++) r[i] = a[ADDR_WID-1-i];
    return r;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_i) state_nxt = S_LOAD;
      S_LOAD:   if (din_vld_i && cnt_last) state_nxt = S_CALC;
      S_CALC:   state_nxt = S_WAIT;
      S_WAIT:   if (lat_zero) state_nxt = stg_last ? S_UNLOAD : S_CALC;
      S_UNLOAD: if (dout_rdy_i && cnt_last) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Sample counter, stage index, latency counter and bank select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      stage    <= '0;
      lat_cnt  <= '0;
      bank_sel <= 1'b0;
`ifdef FFT_CTRL_SCALE_EN
      blk_exp  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (start_i) begin
          cnt <= '0;
`ifdef FFT_CTRL_SCALE_EN
          blk_exp <= '0;
`endif
        end
        S_LOAD: if (din_vld_i) begin
          cnt <= cnt + ADDR_WID'(1);
          if (cnt_last) begin
            stage    <= '0;
            bank_sel <= 1'b0;
          end
        end
        S_CALC: lat_cnt <= LAT_W'(BFLY_LAT - 1);
        S_WAIT: begin
          if (lat_zero) begin
            bank_sel <= ~bank_sel;
`ifdef FFT_CTRL_SCALE_EN
            blk_exp  <= blk_exp + STG_W'(1);
`endif
            if (stg_last) cnt   <= '0;
            else          stage <= stage + STG_W'(1);
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        S_UNLOAD: if (dout_rdy_i) cnt <= cnt + ADDR_WID'(1);
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state; only ld_we_o sees an input
  always_comb begin
    busy_o      = (state != S_IDLE);
    done_o      = (state == S_DONE);
    din_rdy_o   = (state == S_LOAD);
    ld_we_o     = (state == S_LOAD) && din_vld_i;
    ld_addr_o   = (state == S_LOAD) ? cnt : '0;
    stage_o     = (state == S_CALC || state == S_WAIT) ? stage : '0;
    bf_en_o     = (state == S_CALC);
    wb_en_o     = (state == S_WAIT) && lat_zero;
    bank_sel_o  = bank_sel;
    dout_vld_o  = (state == S_UNLOAD);
    ul_addr_o   = (state == S_UNLOAD) ? bitrev(cnt) : '0;
    dout_last_o = (state == S_UNLOAD) && cnt_last;
`ifdef FFT_CTRL_SCALE_EN
    scale_o     = (state == S_CALC || state == S_WAIT);
    blk_exp_o   = blk_exp;
`endif
  end

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Randomized bench for fft_stage_ctrl: a frame-level model derives every output from
// handshake counts and elapsed compute cycles; literal pins anchor the model.
`ifndef STG_WID
`define STG_WID 3
`endif

module tb_fft_stage_ctrl;
  localparam int N    = 64;
  localparam int AW   = 6;
  localparam int S    = 6;
  localparam int L    = 3;
  localparam int SPAN = S * (L + 1);

  logic clk = 1'b0;
  logic rst_n;
  logic start_i, din_vld_i, dout_rdy_i;
  logic busy_o, done_o, din_rdy_o, ld_we_o, bf_en_o, wb_en_o, bank_sel_o;
  logic dout_vld_o, dout_last_o;
  logic [AW-1:0] ld_addr_o, ul_addr_o;
  logic [`STG_WID-1:0] stage_o;
`ifdef FFT_CTRL_SCALE_EN
  logic scale_o;
  logic [`STG_WID-1:0] blk_exp_o;
`endif

  fft_stage_ctrl #(.FFT_LEN(N), .ADDR_WID(AW), .STG_NUM(S), .BFLY_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .din_vld_i(din_vld_i), .din_rdy_o(din_rdy_o), .ld_we_o(ld_we_o), .ld_addr_o(ld_addr_o),
    .stage_o(stage_o), .bf_en_o(bf_en_o), .wb_en_o(wb_en_o), .bank_sel_o(bank_sel_o),
    .dout_vld_o(dout_vld_o), .dout_rdy_i(dout_rdy_i), .ul_addr_o(ul_addr_o),
    .dout_last_o(dout_last_o)
`ifdef FFT_CTRL_SCALE_EN
    , .scale_o(scale_o), .blk_exp_o(blk_exp_o)
`endif
  );

  always #5 clk = ~clk;

  // Frame-level model: phase, handshake count n, compute-cycle index k
  typedef enum int {P_IDLE, P_LOAD, P_COMP, P_UNL, P_DONE} phase_t;
  phase_t m_phase = P_IDLE;
  int m_n = 0, m_k = 0, m_bank_rest = 0, m_exp_rest = 0;

  int n_chk = 0, n_pass = 0, cyc = 0;
  int vld_mode = 0, rdy_mode = 0;
  bit rec = 0, fin_req = 0;
  int pins_req = 0, pins_done = 0, n_to = 0;

  int bf_t[$], bf_stg[$], bf_bank[$], wb_t[$], ul_q[$], lst_q[$];
  int last_ld_t = 0, hs_t = 0, done_t = 0, ul_bank = -1, done_exp = -1;
  int exp_ul[5]   = '{0, 32, 16, 48, 8};
  int exp_bank[6] = '{0, 1, 0, 1, 0, 1};

  function automatic int rev(input int x);
    int r = 0;
    for (int i = 0; i < AW; i++) r = (r << 1) | ((x >> i) & 1);
    return r;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = P_IDLE; m_n = 0; m_k = 0; m_bank_rest = 0; m_exp_rest = 0;
      end else begin
        case (m_phase)
          P_IDLE: if (start_i) begin m_phase = P_LOAD; m_n = 0; m_exp_rest = 0; end
          P_LOAD: if (din_vld_i) begin
            if (m_n == N - 1) begin m_phase = P_COMP; m_k = 0; end
            else m_n++;
          end
          P_COMP: if (m_k == SPAN - 1) begin
            m_phase = P_UNL; m_n = 0; m_bank_rest = S % 2; m_exp_rest = S;
          end else m_k++;
          P_UNL: if (dout_rdy_i) begin
            if (m_n == N - 1) m_phase = P_DONE;
            else m_n++;
          end
          default: m_phase = P_IDLE;
        endcase
      end
    end
  end

  task automatic check_model();
    bit comp = (m_phase == P_COMP);
    int st = m_k / (L + 1);
    int ph = m_k % (L + 1);
    chk("busy", 32'(busy_o), 32'(m_phase != P_IDLE));
    chk("done", 32'(done_o), 32'(m_phase == P_DONE));
    chk("din_rdy", 32'(din_rdy_o), 32'(m_phase == P_LOAD));
    chk("ld_we", 32'(ld_we_o), 32'(m_phase == P_LOAD && din_vld_i));
    if (m_phase == P_LOAD) chk("ld_addr", 32'(ld_addr_o), m_n);
    chk("stage", 32'(stage_o), comp ? st : 0);
    chk("bf_en", 32'(bf_en_o), 32'(comp && ph == 0));
    chk("wb_en", 32'(wb_en_o), 32'(comp && ph == L));
    chk("bank_sel", 32'(bank_sel_o), comp ? st % 2 : m_bank_rest);
    chk("dout_vld", 32'(dout_vld_o), 32'(m_phase == P_UNL));
    if (m_phase == P_UNL) chk("ul_addr", 32'(ul_addr_o), rev(m_n));
    chk("dout_last", 32'(dout_last_o), 32'(m_phase == P_UNL && m_n == N - 1));
`ifdef FFT_CTRL_SCALE_EN
    chk("scale", 32'(scale_o), 32'(comp));
    chk("blk_exp", 32'(blk_exp_o), comp ? st : m_exp_rest);
`endif
  endtask

  task automatic check_reset_zero();
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_din_rdy", 32'(din_rdy_o), 0);
    chk("rst_ld_we", 32'(ld_we_o), 0);
    chk("rst_stage", 32'(stage_o), 0);
    chk("rst_bf_en", 32'(bf_en_o), 0);
    chk("rst_wb_en", 32'(wb_en_o), 0);
    chk("rst_bank", 32'(bank_sel_o), 0);
    chk("rst_dout_vld", 32'(dout_vld_o), 0);
    chk("rst_ul_addr", 32'(ul_addr_o), 0);
    chk("rst_last", 32'(dout_last_o), 0);
  endtask

  task automatic record();
    if (ld_we_o && ld_addr_o == AW'(N - 1)) last_ld_t = cyc;
    if (bf_en_o) begin
      bf_t.push_back(cyc); bf_stg.push_back(int'(stage_o)); bf_bank.push_back(int'(bank_sel_o));
    end
    if (wb_en_o) wb_t.push_back(cyc);
    if (dout_vld_o && ul_q.size() == 0) ul_bank = int'(bank_sel_o);
    if (dout_vld_o && dout_rdy_i) begin
      ul_q.push_back(int'(ul_addr_o)); lst_q.push_back(int'(dout_last_o)); hs_t = cyc;
    end
    if (done_o) begin
      done_t = cyc;
`ifdef FFT_CTRL_SCALE_EN
      done_exp = int'(blk_exp_o);
`endif
    end
  endtask

  task automatic do_pins();
    chk("bf_count", bf_t.size(), 6);
    chk("wb_count", wb_t.size(), 6);
    chk("ul_count", ul_q.size(), 64);
    if (bf_t.size() > 0) chk("first_bf_after_load", bf_t[0] - last_ld_t, 1);
    for (int i = 0; i < bf_t.size() && i < 6; i++) begin
      chk("bf_stage", bf_stg[i], i);
      chk("bf_bank", bf_bank[i], exp_bank[i]);
      if (i > 0) chk("bf_spacing", bf_t[i] - bf_t[i-1], 4);
      if (i < wb_t.size()) chk("wb_delay", wb_t[i] - bf_t[i], 3);
    end
    chk("unload_bank", ul_bank, 0);
    for (int i = 0; i < 5 && i < ul_q.size(); i++) chk("ul_first", ul_q[i], exp_ul[i]);
    if (ul_q.size() == 64) begin
      chk("ul_final", ul_q[63], 63);
      chk("last_on_64th", lst_q[63], 1);
      chk("last_not_63rd", lst_q[62], 0);
    end
    chk("done_after_last", done_t - hs_t, 1);
`ifdef FFT_CTRL_SCALE_EN
    chk("blk_exp_at_done", done_exp, 6);
`endif
  endtask

  // Single compare process, sampling on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      check_model();
      if (!rst_n) check_reset_zero();
      if (rec) record();
      if (pins_req != pins_done) begin do_pins(); pins_done++; end
      if (fin_req) begin
        chk("frame_budget", n_to, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    start_i    = 1'b0;
    din_vld_i  = (vld_mode == 0) ? 1'b1 : 1'($urandom % 2);
    dout_rdy_i = (rdy_mode == 0) ? 1'b1 :
                 (rdy_mode == 1) ? 1'($urandom % 3 == 0) : 1'($urandom % 2);
  endtask

  task automatic run_frame(input int vm, input int rm, input bit poke, input bit rst10);
    bit fin = 0;
    vld_mode = vm;
    rdy_mode = rm;
    start_i  = 1'b1;
    tick();
    for (int n = 0; n < 4000 && !fin; n++) begin
      tick();
      if (m_phase == P_IDLE) fin = 1;
      else if (rst10 && m_phase == P_UNL && m_n == 10) begin
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        fin = 1;
      end else begin
        if (poke && m_phase == P_COMP && (m_k % (L + 1)) == 1) start_i = 1'b1;
        if (poke && m_phase == P_DONE) start_i = 1'b1;
      end
    end
    if (!fin) begin
      $display("FAIL frame_timeout cycle %0d: got running expected idle", cyc);
      n_to++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; din_vld_i = 1'b0; dout_rdy_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(); tick();
    rec = 1'b1;
    run_frame(0, 0, 1'b0, 1'b0);
    rec = 1'b0;
    pins_req++;
    tick(); tick();
    run_frame(1, 1, 1'b1, 1'b0);
    tick(); tick();
    run_frame(1, 2, 1'b0, 1'b1);
    tick(); tick();
    run_frame(0, 2, 1'b1, 1'b0);
    tick(); tick();
    fin_req = 1'b1;
    repeat (4) @(posedge clk);
    $display("FAIL finish_not_reached cycle %0d: got running expected finished", cyc);
    $fatal(1);
  end

endmodule
